// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - PC-indexed saturating-counter branch predictor with static modes and stats
module bht_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 8,
    parameter int CTR_BITS   = 2,
    parameter int INIT_CTR   = 1,
    parameter int MODE       = 0,
    parameter int STAT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 if_ask_for_prediction,
    input  logic [PC_WIDTH-1:0]  if_pc,
    output logic                 predicted_jump,
    output logic                 prediction_valid,
    input  logic                 rob_enable_predictor,
    input  logic [PC_WIDTH-1:0]  rob_pc,
    input  logic                 real_jump_or_not,
    input  logic                 rob_predicted_jump,
    output logic [STAT_BITS-1:0] update_count,
    output logic [STAT_BITS-1:0] mispredict_count
);

    localparam int                ENTRIES  = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);

    logic [CTR_BITS-1:0]   table_q [ENTRIES];
    logic [INDEX_BITS-1:0] ask_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0]   cur_upd;
    logic [CTR_BITS-1:0]   upd_ctr;
    logic [CTR_BITS-1:0]   ask_ctr;
    logic                  pred_bit;
    logic [STAT_BITS-1:0]  upd_cnt_next;
    logic [STAT_BITS-1:0]  mis_cnt_next;
    logic                  unused_pc_bits;

    // Word-aligned PCs: drop the byte offset, keep INDEX_BITS above it; upper bits alias.
    assign ask_idx = if_pc[INDEX_BITS+1:2];
    assign upd_idx = rob_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{if_pc[PC_WIDTH-1:INDEX_BITS+2], if_pc[1:0],
                              rob_pc[PC_WIDTH-1:INDEX_BITS+2], rob_pc[1:0]};

    always_comb begin
        cur_upd = table_q[upd_idx];
        upd_ctr = cur_upd;
        if (real_jump_or_not) begin
            if (cur_upd != CTR_MAX) upd_ctr = cur_upd + 1'b1;
        end else begin
            if (cur_upd != '0) upd_ctr = cur_upd - 1'b1;
        end
    end

    // A same-cycle update to the queried entry is forwarded so the prediction sees it.
    always_comb begin
        ask_ctr = table_q[ask_idx];
        if (MODE == 0 && rob_enable_predictor && upd_idx == ask_idx) ask_ctr = upd_ctr;
        if (MODE == 1)      pred_bit = 1'b1;
        else if (MODE == 2) pred_bit = 1'b0;
        else                pred_bit = ask_ctr[CTR_BITS-1];
    end

    always_comb begin
        upd_cnt_next = update_count;
        mis_cnt_next = mispredict_count;
        if (update_count != '1) upd_cnt_next = update_count + 1'b1;
        if (rob_predicted_jump != real_jump_or_not && mispredict_count != '1)
            mis_cnt_next = mispredict_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
            predicted_jump   <= 1'b0;
            prediction_valid <= 1'b0;
            update_count     <= '0;
            mispredict_count <= '0;
        end else if (rdy) begin
            prediction_valid <= if_ask_for_prediction;
            if (if_ask_for_prediction) predicted_jump <= pred_bit;
            if (rob_enable_predictor) begin
                if (MODE == 0) table_q[upd_idx] <= upd_ctr;
                update_count     <= upd_cnt_next;
                mispredict_count <= mis_cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - randomized and directed bench for bht_predictor against a behavioural model
module tb_bht_predictor;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        ask;
    logic [31:0] ipc;
    logic        en;
    logic [31:0] rpc;
    logic        real_j;
    logic        rpj;

    logic        pj0, pv0, pj1, pv1;
    logic [31:0] uc0, mc0, uc1, mc1;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    // Behavioural model state
    int     mctr [256];
    logic   ev, ej, ej1;
    longint muc, mmc;

    bht_predictor #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_ask_for_prediction(ask), .if_pc(ipc),
        .predicted_jump(pj0), .prediction_valid(pv0),
        .rob_enable_predictor(en), .rob_pc(rpc),
        .real_jump_or_not(real_j), .rob_predicted_jump(rpj),
        .update_count(uc0), .mispredict_count(mc0)
    );

    bht_predictor #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_ask_for_prediction(ask), .if_pc(ipc),
        .predicted_jump(pj1), .prediction_valid(pv1),
        .rob_enable_predictor(en), .rob_pc(rpc),
        .real_jump_or_not(real_j), .rob_predicted_jump(rpj),
        .update_count(uc1), .mispredict_count(mc1)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 256);
    endfunction

    // One clock of the reference behaviour, using the inputs sampled at the edge.
    task automatic model_update();
        int i;
        if (!rst) begin
            for (int k = 0; k < 256; k++) mctr[k] = 1;
            ev = 0; ej = 0; ej1 = 0; muc = 0; mmc = 0;
        end else if (rdy) begin
            if (en) begin
                i = idx_of(rpc);
                if (real_j) mctr[i] = (mctr[i] + 1 > 3) ? 3 : mctr[i] + 1;
                else        mctr[i] = (mctr[i] - 1 < 0) ? 0 : mctr[i] - 1;
                if (muc < 64'hFFFF_FFFF) muc++;
                if (rpj != real_j && mmc < 64'hFFFF_FFFF) mmc++;
            end
            ev = ask;
            if (ask) begin
                ej  = (mctr[idx_of(ipc)] >= 2);
                ej1 = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic a, input logic [31:0] ap, input logic e,
                         input logic [31:0] up, input logic r, input logic p);
        ask = a; ipc = ap; en = e; rpc = up; real_j = r; rpj = p;
        tick();
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid0", pv0, ev);
            chk("jump0", pj0, ej);
            chk("upd0", uc0, muc);
            chk("mis0", mc0, mmc);
            chk("valid1", pv1, ev);
            chk("jump1", pj1, ej1);
            chk("upd1", uc1, muc);
            chk("mis1", mc1, mmc);
        end
    end

    initial begin
        rst = 0; rdy = 1; ask = 0; ipc = 0; en = 0; rpc = 0; real_j = 0; rpj = 0;
        tick();
        tick();
        rst = 1;
        cmp_en = 1;
        chk("reset_valid", pv0, 1'b0);
        chk("reset_jump", pj0, 1'b0);
        chk("reset_counts", {uc0, mc0}, 64'd0);

        drive(1, 32'h100, 0, 0, 0, 0);
        chk("t1_valid", pv0, 1'b1);
        chk("t1_jump", pj0, 1'b0);
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_idle_valid", pv0, 1'b0);

        drive(0, 0, 1, 32'h100, 1, 0);
        drive(0, 0, 1, 32'h100, 1, 0);
        drive(1, 32'h100, 0, 0, 0, 0);
        chk("t2_taken_jump", pj0, 1'b1);
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 32'h100, 1, 1);
        drive(0, 0, 1, 32'h100, 0, 1);
        drive(0, 0, 1, 32'h100, 0, 1);
        drive(1, 32'h100, 0, 0, 0, 0);
        chk("t2_sat_jump", pj0, 1'b0);
        chk("t2_counts", {uc0, mc0}, {32'd9, 32'd4});

        drive(1, 32'h104, 1, 32'h104, 1, 1);
        chk("t3_forward", pj0, 1'b1);

        drive(0, 0, 1, 32'h100, 1, 1);
        drive(0, 0, 1, 32'h100, 1, 1);
        drive(1, 32'h500, 0, 0, 0, 0);
        chk("t4_alias", pj0, 1'b1);
        drive(1, 32'h104, 0, 0, 0, 0);
        chk("t4_other", pj0, 1'b1);
        drive(1, 32'h108, 0, 0, 0, 0);
        chk("t4_fresh", pj0, 1'b0);
        chk("t4_counts", {uc0, mc0}, {32'd12, 32'd4});

        rdy = 0;
        for (int k = 0; k < 3; k++) drive(1, 32'h108, 1, 32'h108, 1, 0);
        chk("t5_valid_held", pv0, 1'b1);
        chk("t5_counts", {uc0, mc0}, {32'd12, 32'd4});
        rdy = 1;
        drive(1, 32'h108, 0, 0, 0, 0);
        chk("t5_ctr_unchanged", pj0, 1'b0);

        rst = 0;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1;
        for (int k = 0; k < 4; k++) drive(0, 0, 1, 32'h200 + k * 4, 0, 1);
        drive(1, 32'h3C, 0, 0, 0, 0);
        chk("t6_static_jump", pj1, 1'b1);
        chk("t6_counts", {uc1, mc1}, {32'd4, 32'd4});
        rst = 0;
        drive(1, 32'h3C, 1, 32'h3C, 1, 0);
        chk("t6_reset_outputs", {pv1, pj1, pv0, pj0}, 4'b0);
        chk("t6_reset_counts", {uc1, mc1}, 64'd0);
        rst = 1;

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            rdy = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 1),
                  ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2),
                  $urandom_range(0, 1),
                  ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        end

        @(negedge clk);
        #1;
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
